// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state type, byte width,
// the fixed field order of a boot frame, and the image-size helper.
package prog_loader_pkg;

  localparam int BYTE_W = 8;

  // Boot frame layout: big-endian word count, then HI/LO byte pairs,
  // optionally followed by one XOR checksum byte.
  localparam int FRAME_LEN_HI_POS      = 0;
  localparam int FRAME_LEN_LO_POS      = 1;
  localparam int FRAME_DATA_POS        = 2;
  localparam int FRAME_BYTES_PER_WORD  = 2;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHK     = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  // Largest image that fits in an instruction memory of the given address width.
  function automatic int max_words(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream link into the program loader (valid/ready handshake).
//   in_valid : source has a byte on in_data
//   in_data  : stream byte
//   in_ready : sink accepts the byte; transfer = in_valid & in_ready at rising clk
// Modports: master = byte source, slave = loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a framed byte stream, assembles 16-bit
// instruction words, writes them sequentially into instruction memory and
// holds the processor's pc_enable (cpu_run) low until the image is complete.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   load_req     single-cycle pulse; restarts loading from RUN or ERR
//   s_in         byte stream (prog_loader_if.slave: in_valid/in_data/in_ready)
//   imem_we      instruction memory write strobe, one cycle per word
//   imem_addr    write address (holds when imem_we = 0)
//   imem_wdata   write data (holds when imem_we = 0)
//   cpu_run      drives the processor's pc_enable
//   load_done    image loaded successfully
//   load_err     frame error
//   words_loaded words written in the current load
//
// Build option: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (covering LEN_HI through the last DATA_LO) before RUN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ARQ    = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  prog_loader_if.slave      s_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ARQ-1:0]    imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MAX_N = max_words(ADDR_W);

  loader_state_t     r_state;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ARQ-1:0]    r_wdata;
  logic              r_cpu_run;
  logic              r_load_done;
  logic              r_load_err;
  logic [ADDR_W:0]   r_idx;
  logic [15:0]       r_n;
  logic [BYTE_W-1:0] r_len_hi;
  logic [BYTE_W-1:0] r_hi;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_xor;
`endif

  logic              w_hs;
  logic [15:0]       w_n;
  logic              w_too_big;
  logic [ADDR_W:0]   w_idx_nxt;
  logic              w_last;

  assign w_hs      = s_in.in_valid & r_in_ready;
  assign w_n       = {r_len_hi, s_in.in_data};
  assign w_too_big = (32'(w_n) > 32'(MAX_N));
  assign w_idx_nxt = r_idx + (ADDR_W+1)'(1);
  // Index is one wider than the address, so N == 2**ADDR_W ends on the
  // all-ones address without the counter wrapping.
  assign w_last    = (32'(w_idx_nxt) == 32'(r_n));

  // Instruction byte staging; pure data, so left out of reset.
  always_ff @(posedge clk) begin
    if (w_hs && (r_state == ST_DATA_HI)) r_hi <= s_in.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LEN_HI;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_run   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_idx       <= '0;
      r_n         <= '0;
      r_len_hi    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (w_hs && (r_state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO}))
        r_xor <= r_xor ^ s_in.in_data;
`endif
      case (r_state)
        ST_LEN_HI: begin
          // First state after reset or restart; ready rises here.
          r_in_ready <= 1'b1;
          if (w_hs) begin
            r_len_hi <= s_in.in_data;
            r_state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_hs) begin
            r_n <= w_n;
            if (w_too_big) begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
              r_in_ready <= 1'b0;
            end else if (w_n == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              r_state     <= ST_CHK;
`else
              r_state     <= ST_RUN;
              r_cpu_run   <= 1'b1;
              r_load_done <= 1'b1;
              r_in_ready  <= 1'b0;
`endif
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (w_hs) r_state <= ST_DATA_LO;
        end
        ST_DATA_LO: begin
          // Write strobe is registered so it lands in the WRITE cycle.
          if (w_hs) begin
            r_we       <= 1'b1;
            r_addr     <= r_idx[ADDR_W-1:0];
            r_wdata    <= {r_hi, s_in.in_data};
            r_in_ready <= 1'b0;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_idx <= w_idx_nxt;
          if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state     <= ST_CHK;
            r_in_ready  <= 1'b1;
`else
            r_state     <= ST_RUN;
            r_cpu_run   <= 1'b1;
            r_load_done <= 1'b1;
`endif
          end else begin
            r_state    <= ST_DATA_HI;
            r_in_ready <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_hs) begin
            r_in_ready <= 1'b0;
            if (s_in.in_data == r_xor) begin
              r_state     <= ST_RUN;
              r_cpu_run   <= 1'b1;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: begin
          if (load_req) begin
            r_state     <= ST_LEN_HI;
            r_cpu_run   <= 1'b0;
            r_load_done <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
          end
        end
        ST_ERR: begin
          if (load_req) begin
            r_state    <= ST_LEN_HI;
            r_load_err <= 1'b0;
            r_idx      <= '0;
            r_in_ready <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        default: begin
          // Unreachable encoding (CHK without checksum): park safely in ERR.
          r_state    <= ST_ERR;
          r_load_err <= 1'b1;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign cpu_run       = r_cpu_run;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign words_loaded  = r_idx;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: random-gap byte driver, a queue of expected
// memory writes built from the frame contents, and a negedge monitor that
// pops and compares each write the loader issues.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W = 13;
  localparam int ARQ    = 16;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_req = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [ARQ-1:0]    imem_wdata;
  logic              cpu_run;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  prog_loader_if s_if ();

  prog_loader #(.ARQ(ARQ), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .s_in         (s_if),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ARQ-1:0]    data;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write pending", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", 32'(imem_wdata), 32'(e.data));
        chk("ready_in_write", 32'(s_if.in_ready), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = b;
    while (s_if.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: in_ready stayed low for byte 0x%0h", b);
    end else begin
      @(negedge clk);
    end
    s_if.in_valid = 1'b0;
    s_if.in_data  = 8'($urandom);
  endtask

  // Reference model: frame bytes and expected writes come straight from
  // the frame rules (index i gets word i; oversize frames write nothing).
  task automatic run_frame(input logic [15:0] n, input logic [15:0] words[$],
                           input int max_gap, input bit corrupt);
    logic [7:0] bytes[$];
    logic [7:0] x;
    bit ok;
    ok = (int'(n) <= MAXW);
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        wr_t e;
        bytes.push_back(words[i][15:8]);
        bytes.push_back(words[i][7:0]);
        e.addr = ADDR_W'(i);
        e.data = words[i];
        exp_q.push_back(e);
      end
    end
    x = 8'h00;
    foreach (bytes[i]) x = x ^ bytes[i];
`ifdef PROG_LOADER_CHECKSUM_EN
    if (ok) bytes.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
    foreach (bytes[i]) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(bytes[i]);
    end
  endtask

  task automatic check_outcome(input string tag, input logic [15:0] n, input bit corrupt);
    int  k = 0;
    bit  ok, run;
    ok  = (int'(n) <= MAXW);
`ifdef PROG_LOADER_CHECKSUM_EN
    run = ok && !corrupt;
`else
    run = ok;
`endif
    while (cpu_run !== 1'b1 && load_err !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      total++;
      bad++;
      $display("FAIL %s_outcome_timeout: neither cpu_run nor load_err rose", tag);
    end
    @(negedge clk);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(run));
    chk({tag, "_load_done"}, 32'(load_done), 32'(run));
    chk({tag, "_load_err"}, 32'(load_err), 32'(!run));
    chk({tag, "_words"}, 32'(words_loaded), ok ? 32'(n) : 32'd0);
    chk({tag, "_ready"}, 32'(s_if.in_ready), 32'd0);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_load_req(input string tag);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk({tag, "_cpu_run_drop"}, 32'(cpu_run), 32'd0);
    chk({tag, "_done_clr"}, 32'(load_done), 32'd0);
    chk({tag, "_err_clr"}, 32'(load_err), 32'd0);
    chk({tag, "_words_clr"}, 32'(words_loaded), 32'd0);
    chk({tag, "_ready"}, 32'(s_if.in_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(s_if.in_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w[$];
    logic [15:0] nr;
    s_if.in_valid = 1'b0;
    s_if.in_data  = 8'h00;
    #1 rst = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed load, continuous stream.
    w = '{16'h1234, 16'hABCD, 16'h0F0F};
    run_frame(16'd3, w, 0, 1'b0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("n3_run_after_1", 32'(cpu_run), 32'd0);
    @(negedge clk);
    chk("n3_run_after_2", 32'(cpu_run), 32'd1);
    chk("n3_done_after_2", 32'(load_done), 32'd1);
`endif
    check_outcome("n3", 16'd3, 1'b0);
    pulse_load_req("req_run");

    // Same image with random gaps between bytes.
    run_frame(16'd3, w, 3, 1'b0);
    check_outcome("n3_gaps", 16'd3, 1'b0);
    pulse_load_req("req_run2");

    // Empty image.
    w = {};
    run_frame(16'd0, w, 2, 1'b0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("n0_run_next", 32'(cpu_run), 32'd1);
`endif
    check_outcome("n0", 16'd0, 1'b0);
    pulse_load_req("req_run3");

    // One word past capacity.
    run_frame(16'h2001, w, 1, 1'b0);
    check_outcome("n2001", 16'h2001, 1'b0);
    s_if.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_ready_hold", 32'(s_if.in_ready), 32'd0);
    chk("err_hold", 32'(load_err), 32'd1);
    s_if.in_valid = 1'b0;
    pulse_load_req("req_err");
    w = '{16'($urandom)};
    run_frame(16'd1, w, 2, 1'b0);
    check_outcome("n1_after_err", 16'd1, 1'b0);
    pulse_load_req("req_run4");

    // Reset after two of three words.
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = ADDR_W'(i);
      e.data = 16'h5A00 + 16'(i);
      exp_q.push_back(e);
    end
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h5A); send_byte(8'h00);
    send_byte(8'h5A); send_byte(8'h01);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    chk("mid_reset_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    w = '{16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(16'd3, w, 2, 1'b0);
    check_outcome("reload", 16'd3, 1'b0);
    pulse_load_req("req_run5");

    // Random images.
    for (int t = 0; t < 4; t++) begin
      nr = 16'($urandom_range(1, 20));
      w = {};
      for (int i = 0; i < int'(nr); i++) w.push_back(16'($urandom));
      run_frame(nr, w, 2, 1'b0);
      check_outcome("rand", nr, 1'b0);
      pulse_load_req("req_rand");
    end

    // Full memory: last word lands on the all-ones address.
    w = {};
    for (int i = 0; i < MAXW; i++) w.push_back(16'($urandom));
    run_frame(16'(MAXW), w, 0, 1'b0);
    check_outcome("full", 16'(MAXW), 1'b0);
    chk("full_last_addr", 32'(imem_addr), 32'(MAXW - 1));
    pulse_load_req("req_full");

`ifdef PROG_LOADER_CHECKSUM_EN
    // 0x00^0x01^0x12^0x34 = 0x27 is correct; 0x26 must be rejected.
    w = '{16'h1234};
    run_frame(16'd1, w, 0, 1'b0);
    check_outcome("chk_good", 16'd1, 1'b0);
    pulse_load_req("req_chk");
    run_frame(16'd1, w, 0, 1'b1);
    check_outcome("chk_bad", 16'd1, 1'b1);
    pulse_load_req("req_chk_err");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Front-end boot block that sits directly upstream of the pipelined processor. It receives a byte stream carrying a program image over a valid/ready link.
- It assembles 16-bit instruction words and writes them sequentially into instruction memory.
- It holds the processor's pc_enable low until the image is complete, then releases it.
- It also reports load status and supports reload on request.

Parameters:
- ARQ, 16, instruction/data word width (must be 16; two bytes per word).
- ADDR_W, 13, instruction memory address width; matches the fetch/jump address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load_req  in  1  single-cycle pulse; restarts loading from RUN or ERR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; handshake = in_valid & in_ready at the rising edge.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  ARQ  write data.
- cpu_run  out  1  drives processor pc_enable.
- load_done  out  1  image loaded successfully.
- load_err  out  1  frame error.
- words_loaded  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: N, a 16-bit word count, big-endian.
  - Then N words, each as HI byte then LO byte.
  - With CHECKSUM_EN, one trailing checksum byte follows.
- Reset (rst low, asynchronous):
  - All outputs are 0, including in_ready.
  - Internal counters are cleared.
  - State is LEN_HI.
  - Reset mid-load abandons the frame; no further writes occur.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK (optional), RUN, ERR. All outputs are registered or decoded from state.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. It is 0 in WRITE, RUN and ERR.
- LEN_HI: on handshake, latch the high byte of N, then go to LEN_LO.
- LEN_LO: on handshake, latch the low byte of N, then branch:
  - N > 2**ADDR_W: go to ERR.
  - N == 0: go to CHK (if enabled), otherwise RUN.
  - Otherwise: go to DATA_HI.
- DATA_HI: on handshake, latch hi byte, go to DATA_LO.
- DATA_LO: on handshake, latch lo byte, go to WRITE.
- WRITE (exactly one cycle):
  - imem_we = 1, imem_addr = current word index, imem_wdata = {hi, lo}.
  - The index and words_loaded increment at the end of the cycle.
  - Next state is DATA_HI if more words remain, otherwise CHK or RUN.
- Latency: imem_we is asserted the cycle after the DATA_LO handshake. Without checksum, cpu_run rises 2 cycles after the last byte handshake.
- Address wrap: with N == 2**ADDR_W, the last word goes to the all-ones address. The index never wraps inside one load.
- RUN:
  - cpu_run = 1, load_done = 1.
  - The stream is ignored.
  - load_req: cpu_run drops the next cycle, load_done, index and words_loaded clear, state becomes LEN_HI.
- ERR:
  - load_err = 1, cpu_run = 0, load_done = 0.
  - Only load_req exits, to LEN_HI, clearing load_err and counters.
- load_req while in LEN_*, DATA_*, WRITE or CHK is ignored.
- in_valid low stalls any byte state indefinitely; no timeout.
- in_data is sampled only on handshake.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR covers every byte from LEN_HI through the last DATA_LO.
  - After the last word (or after LEN_LO when N == 0), state CHK accepts one byte.
  - If the byte equals the running XOR, go to RUN; otherwise go to ERR. Words already written remain in memory.
  - The XOR clears on reset and on load_req.
- When not defined: no CHK state, no XOR register; the last WRITE (or LEN_LO with N == 0) goes straight to RUN.

Decomposition:
- Shared package prog_loader_pkg:
  - state enum type loader_state_t.
  - localparam BYTE_W = 8.
  - Frame field order constants.
  - Function max_words(ADDR_W) returning 2**ADDR_W.
- No sub-module: one FSM plus small datapath (N register, hi byte, index counter, XOR) in a single file.
- At top level, cpu_run connects to the processor's pc_enable, and the imem_* ports connect to the instruction memory write port.

Test Plan:
- Load N=3, words 0x1234, 0xABCD, 0x0F0F, continuous in_valid -> three single-cycle imem_we at addr 0/1/2 with matching data; words_loaded=3; cpu_run=1 and load_done=1 two cycles after the 0x0F handshake.
- Same stream with in_valid toggling 1-0-0-1 and random gaps -> identical writes, none dropped or duplicated; in_ready=0 during each WRITE cycle.
- N=0 (bytes 0x00 0x00) -> no imem_we; cpu_run=1 the cycle after the LEN_LO handshake.
- N=0x2001 -> load_err=1, cpu_run=0, in_ready=0; load_req pulse -> load_err=0, state LEN_HI, a valid N=1 load then succeeds.
- rst low after 2 of 3 words -> all outputs 0 asynchronously; after release, the full reload writes from addr 0; load_req in RUN drops cpu_run the next cycle.
- PROG_LOADER_CHECKSUM_EN, N=1, word 0x1234 -> checksum 0x00^0x01^0x12^0x34 = 0x27 gives RUN; sending 0x26 gives ERR with load_done=0.
